button_int_ctrl: RTL and testbench

- Interrupt controller for the four user buttons feeding the CPU core.
- Synchronises and debounces the raw buttons, then latches press events as pending.
- Arbitrates the pending events by fixed priority and presents one request at a time with a handler vector.
- Sequences request, acknowledge and return with the core's exe stage, so only one handler is ever in service and no press is lost.

---
 rtl/button_int_ctrl.sv | 144 ++++++++++++++
 tb/tb_button_int_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_int_ctrl.sv
// Button interrupt controller: synchronises and debounces four buttons, latches press events,
// and hands them to the core one at a time by fixed priority with a req/ack/ret handshake.
module button_int_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] VEC_BASE        = 16'h0f80,
    parameter logic [15:0] VEC_STRIDE      = 16'h0020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  buttons_raw,
    input  logic [3:0]  int_enable,
    input  logic        int_ack,
    input  logic        int_ret,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic [1:0]  int_id,
    output logic        in_service,
    output logic [3:0]  pending
);

    localparam int unsigned NB = 4;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NB-1:0]   sync1, sync2;
    logic [NB-1:0]   deb, deb_d;
    logic [CW-1:0]   cnt [NB];
    logic [NB-1:0]   rise;
    logic [NB-1:0]   req_mask;
    logic [NB-1:0]   clr;
    logic [1:0]      win;
    logic [15:0]     win_vec;
    logic            req_nxt;
    logic            svc_nxt;
    logic [1:0]      id_nxt;
    logic [15:0]     vec_nxt;

    // Two-flop synchroniser followed by per-bit stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= buttons_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    // The cycle that completes the stable run also commits the new level.
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise     = deb & ~deb_d;
    assign req_mask = pending & int_enable;
    assign win_vec  = VEC_BASE + 16'(2'd3 - win) * VEC_STRIDE;

    // Fixed priority: highest enabled pending bit wins.
    always_comb begin
        win = 2'd0;
        for (int i = 0; i < NB; i++) begin
            if (req_mask[i]) begin
                win = 2'(i);
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt = state;
        req_nxt   = int_req;
        svc_nxt   = in_service;
        id_nxt    = int_id;
        vec_nxt   = int_vector;
        clr       = '0;
        case (state)
            IDLE: begin
                if (req_mask != '0) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    id_nxt    = win;
                    vec_nxt   = win_vec;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt = SERVICE;
                    req_nxt   = 1'b0;
                    svc_nxt   = 1'b1;
                    clr       = NB'(1) << int_id;
                end
            end
            SERVICE: begin
                if (int_ret) begin
                    state_nxt = IDLE;
                    svc_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                svc_nxt   = 1'b0;
            end
        endcase
    end

    // A fresh debounced edge takes precedence over the clear from an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            in_service <= 1'b0;
            int_id     <= 2'd0;
            int_vector <= 16'h0000;
            pending    <= '0;
        end else begin
            state      <= state_nxt;
            int_req    <= req_nxt;
            in_service <= svc_nxt;
            int_id     <= id_nxt;
            int_vector <= vec_nxt;
            pending    <= (pending & ~clr) | rise;
        end
    end

endmodule

// File: tb/tb_button_int_ctrl.sv
// Directed bench for button_int_ctrl: latency, debounce, priority, handshake and reset behaviour.
module tb_button_int_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  buttons_raw;
    logic [3:0]  int_enable;
    logic        int_ack;
    logic        int_ret;
    logic        int_req;
    logic [15:0] int_vector;
    logic [1:0]  int_id;
    logic        in_service;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    button_int_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons_raw(buttons_raw),
        .int_enable (int_enable),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic pulse_ack();
        @(negedge clk); int_ack = 1'b1;
        @(negedge clk); int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        @(negedge clk); int_ret = 1'b1;
        @(negedge clk); int_ret = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; buttons_raw = 4'h0; int_enable = 4'hf; int_ack = 1'b0; int_ret = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", int_req); end
        checks++; if (int_vector !== 16'h0000) begin errors++; $display("FAIL reset_vec: got %h expected 0000", int_vector); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", int_id); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_svc: got %b expected 0", in_service); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_press_latency();
        @(negedge clk); buttons_raw = 4'b0100;
        repeat (18) @(negedge clk);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL press_edge18_pending: got %b expected 0000", pending); end
        @(negedge clk);
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL press_edge19_pending: got %b expected 0100", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL press_edge19_req: got %b expected 0", int_req); end
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL press_req: got %b expected 1", int_req); end
        checks++; if (int_id !== 2'd2) begin errors++; $display("FAIL press_id: got %0d expected 2", int_id); end
        checks++; if (int_vector !== 16'h0fa0) begin errors++; $display("FAIL press_vec: got %h expected 0fa0", int_vector); end
        repeat (20) @(negedge clk);
        buttons_raw = 4'b0000;
        pulse_ack();
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL press_ack_svc: got %b expected 1", in_service); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL press_ack_req: got %b expected 0", int_req); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL press_ack_pending: got %b expected 0000", pending); end
        pulse_ret();
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL press_ret_svc: got %b expected 0", in_service); end
        repeat (25) @(negedge clk);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL release_no_event: got %b expected 0000", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL release_no_req: got %b expected 0", int_req); end
    endtask

    task automatic test_glitch();
        @(negedge clk); buttons_raw = 4'b0001;
        repeat (10) @(negedge clk);
        buttons_raw = 4'b0000;
        repeat (30) @(negedge clk);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL glitch_pending: got %b expected 0000", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL glitch_req: got %b expected 0", int_req); end
    endtask

    task automatic test_priority_back_to_back();
        @(negedge clk); buttons_raw = 4'b1001;
        repeat (20) @(negedge clk);
        checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL b2b_pending: got %b expected 1001", pending); end
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL b2b_req3: got %b expected 1", int_req); end
        checks++; if (int_id !== 2'd3) begin errors++; $display("FAIL b2b_id3: got %0d expected 3", int_id); end
        checks++; if (int_vector !== 16'h0f80) begin errors++; $display("FAIL b2b_vec3: got %h expected 0f80", int_vector); end
        buttons_raw = 4'b0000;
        pulse_ack();
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL b2b_ack_pending: got %b expected 0001", pending); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL b2b_ack_svc: got %b expected 1", in_service); end
        pulse_ret();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b expected 0", int_req); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL b2b_ret_svc: got %b expected 0", in_service); end
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL b2b_req0: got %b expected 1", int_req); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL b2b_id0: got %0d expected 0", int_id); end
        checks++; if (int_vector !== 16'h0fe0) begin errors++; $display("FAIL b2b_vec0: got %h expected 0fe0", int_vector); end
        pulse_ack();
        pulse_ret();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_frozen_request();
        @(negedge clk); buttons_raw = 4'b0010;
        repeat (20) @(negedge clk);
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL frozen_id_initial: got %0d expected 1", int_id); end
        buttons_raw = 4'b1000;
        repeat (20) @(negedge clk);
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL frozen_pending: got %b expected 1010", pending); end
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL frozen_req: got %b expected 1", int_req); end
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL frozen_id: got %0d expected 1", int_id); end
        checks++; if (int_vector !== 16'h0fc0) begin errors++; $display("FAIL frozen_vec: got %h expected 0fc0", int_vector); end
        buttons_raw = 4'b0000;
        pulse_ack();
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL frozen_ack_pending: got %b expected 1000", pending); end
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL frozen_svc_no_req: got %b expected 0", int_req); end
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL frozen_svc_id: got %0d expected 1", int_id); end
        pulse_ret();
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL frozen_req3: got %b expected 1", int_req); end
        checks++; if (int_id !== 2'd3) begin errors++; $display("FAIL frozen_id3: got %0d expected 3", int_id); end
        checks++; if (int_vector !== 16'h0f80) begin errors++; $display("FAIL frozen_vec3: got %h expected 0f80", int_vector); end
        pulse_ack();
        pulse_ret();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_ignored_pulses();
        pulse_ret();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL idle_ret_req: got %b expected 0", int_req); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL idle_ret_svc: got %b expected 0", in_service); end
        @(negedge clk); buttons_raw = 4'b0100;
        repeat (20) @(negedge clk);
        buttons_raw = 4'b0000;
        pulse_ack();
        pulse_ack();
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL svc_ack_svc: got %b expected 1", in_service); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL svc_ack_req: got %b expected 0", int_req); end
        checks++; if (int_id !== 2'd2) begin errors++; $display("FAIL svc_ack_id: got %0d expected 2", int_id); end
        pulse_ret();
        repeat (20) @(negedge clk);
        // Simultaneous ack and ret while requesting: ack must win.
        @(negedge clk); buttons_raw = 4'b0010;
        repeat (20) @(negedge clk);
        buttons_raw = 4'b0000;
        int_ack = 1'b1; int_ret = 1'b1;
        @(negedge clk);
        int_ack = 1'b0; int_ret = 1'b0;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL ackret_svc: got %b expected 1", in_service); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ackret_pending: got %b expected 0000", pending); end
        pulse_ret();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_enable_and_reset();
        @(negedge clk); int_enable = 4'b1110; buttons_raw = 4'b0001;
        repeat (20) @(negedge clk);
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL disabled_pending: got %b expected 0001", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL disabled_req: got %b expected 0", int_req); end
        buttons_raw = 4'b0000;
        int_enable = 4'hf;
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL enabled_req: got %b expected 1", int_req); end
        checks++; if (int_vector !== 16'h0fe0) begin errors++; $display("FAIL enabled_vec: got %h expected 0fe0", int_vector); end
        pulse_ack();
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL pre_rst_svc: got %b expected 1", in_service); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_svc: got %b expected 0", in_service); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", int_id); end
        checks++; if (int_vector !== 16'h0000) begin errors++; $display("FAIL rst_vec: got %h expected 0000", int_vector); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", int_req); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b expected 0000", pending); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b expected 0", int_req); end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_priority_back_to_back();
        test_frozen_request();
        test_ignored_pulses();
        test_enable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
